// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared widths, status codes, FSM encoding and response entry type
package simple_bus_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {RSP_OK = 2'd0, RSP_MISMATCH = 2'd1, RSP_TIMEOUT = 2'd2} rsp_status_e;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} init_state_e;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      rsp_status_e       status;
   } rsp_entry_t;
endpackage

// File: rtl/simple_bus_rsp_fifo.sv
// simple_bus_rsp_fifo: first-word-fall-through sync FIFO of response entries
module simple_bus_rsp_fifo
   import simple_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  rsp_entry_t i_data,
   input  logic       i_pop,
   output rsp_entry_t o_data,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);
   rsp_entry_t     r_mem [DEPTH];
   logic [AW-1:0]  r_wp;
   logic [AW-1:0]  r_rp;
   logic [AW:0]    r_cnt;
   logic           w_pop;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rp];
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign o_empty = r_cnt == '0;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(w_pop);
      end
   end
   // storage needs no reset; the count gates visibility
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_data;
   end
endmodule

// File: rtl/simple_bus_initiator.sv
// simple_bus_initiator: issues requests to a simple_bus responder and buffers checked replies
module simple_bus_initiator
   import simple_bus_pkg::*;
#(
   parameter int DATA_W     = simple_bus_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_data,
   output logic [DATA_W-1:0] bus_data_in,
   output logic              bus_ready,
   input  logic [DATA_W-1:0] bus_data_out,
   input  logic              bus_valid,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_status,
   output logic [15:0]       spurious_cnt,
   output logic [15:0]       err_cnt
);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam int         TW      = $clog2(TIMEOUT) + 1;
   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_bus_data_in;
   logic [DATA_W-1:0] r_exp;
   logic              r_bus_ready;
   logic [TW-1:0]     r_timer;
   logic [15:0]       r_spur;
   logic [15:0]       r_err;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_timeout;
   logic              w_push;
   rsp_entry_t        w_entry;
   rsp_entry_t        w_head;
   assign req_ready    = r_state == S_IDLE && !w_full;
   assign w_accept     = req_valid && req_ready;
   assign w_timeout    = r_timer == TW'(TIMEOUT - 1);
   assign w_push       = r_state == S_WAIT && (bus_valid || w_timeout);
   assign bus_data_in  = r_bus_data_in;
   assign bus_ready    = r_bus_ready;
   assign rsp_valid    = !w_empty;
   assign rsp_data     = w_head.data;
   assign rsp_status   = w_head.status;
   assign spurious_cnt = r_spur;
   assign err_cnt      = r_err;
   // a reply wins over the timeout when both land on the same cycle
   always_comb begin
      w_entry.data   = bus_valid ? bus_data_out : '0;
      w_entry.status = !bus_valid ? RSP_TIMEOUT : (bus_data_out == r_exp) ? RSP_OK : RSP_MISMATCH;
   end
   // IDLE -> ISSUE -> WAIT -> IDLE, one transaction outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_bus_data_in <= '0;
         r_exp         <= '0;
         r_bus_ready   <= 1'b0;
         r_timer       <= '0;
      end else if (w_accept) begin
         r_state       <= S_ISSUE;
         r_bus_data_in <= req_data;
         r_exp         <= req_data + DATA_W'(1);
         r_bus_ready   <= 1'b1;
      end else if (r_state == S_ISSUE) begin
         r_state     <= S_WAIT;
         r_bus_ready <= 1'b0;
         r_timer     <= '0;
      end else if (w_push) begin
         r_state <= S_IDLE;
      end else if (r_state == S_WAIT) begin
         r_timer <= r_timer + TW'(1);
      end
   end
   // saturating spurious-valid and error counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spur <= '0;
         r_err  <= '0;
      end else begin
         if (bus_valid && r_state != S_WAIT && r_spur != 16'hFFFF) r_spur <= r_spur + 16'd1;
         if (w_push && w_entry.status != RSP_OK && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
      end
   end
   simple_bus_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (rsp_valid && rsp_ready),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
endmodule

// File: tb/tb_simple_bus_initiator.sv
// tb_simple_bus_initiator: directed checks of the initiator against a behavioural responder
module tb_simple_bus_initiator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_data = 8'h00;
   logic [7:0]  bus_data_in;
   logic        bus_ready;
   logic [7:0]  bus_data_out;
   logic        bus_valid;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_status;
   logic [15:0] spurious_cnt;
   logic [15:0] err_cnt;
   int          checks = 0;
   int          errors = 0;
   int          mode = 0;
   logic        inj = 1'b0;
   logic        r_rv = 1'b0;
   logic [7:0]  r_rd = 8'h00;
   always #5 clk = ~clk;
   // responder: mode 0 echoes data+1, mode 1 always returns 8'h10, mode 2 stays silent
   always @(posedge clk) begin
      r_rv <= bus_ready && mode != 2;
      r_rd <= (mode == 1) ? 8'h10 : bus_data_in + 8'h01;
   end
   assign bus_valid    = r_rv | inj;
   assign bus_data_out = r_rd;
   simple_bus_initiator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .bus_data_in  (bus_data_in),
      .bus_ready    (bus_ready),
      .bus_data_out (bus_data_out),
      .bus_valid    (bus_valid),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_status   (rsp_status),
      .spurious_cnt (spurious_cnt),
      .err_cnt      (err_cnt)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_data  = d;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", 16'(req_ready), 16'h1);
      tick();
      req_valid = 1'b0;
   endtask
   task automatic pop_chk(input string tag, input logic [7:0] d, input logic [1:0] s);
      chk({tag, "_valid"}, 16'(rsp_valid), 16'h1);
      chk({tag, "_data"}, 16'(rsp_data), 16'(d));
      chk({tag, "_status"}, 16'(rsp_status), 16'(s));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
   initial begin
      // 1: reset state and a basic transaction
      #12;
      chk("rst_bus_ready", 16'(bus_ready), 16'h0);
      chk("rst_bus_data_in", 16'(bus_data_in), 16'h0);
      chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("rst_req_ready", 16'(req_ready), 16'h1);
      chk("rst_spurious", spurious_cnt, 16'h0);
      chk("rst_err", err_cnt, 16'h0);
      rst_n = 1'b1;
      tick();
      send(8'hA5);
      chk("t1_bus_ready_n", 16'(bus_ready), 16'h1);
      chk("t1_bus_data_in", 16'(bus_data_in), 16'h00A5);
      chk("t1_req_ready_n", 16'(req_ready), 16'h0);
      tick();
      chk("t1_bus_ready_n1", 16'(bus_ready), 16'h0);
      chk("t1_rsp_valid_n1", 16'(rsp_valid), 16'h0);
      tick();
      chk("t1_req_ready_n2", 16'(req_ready), 16'h1);
      pop_chk("t1_rsp", 8'hA6, 2'd0);
      chk("t1_empty", 16'(rsp_valid), 16'h0);
      // 2: wrap-around and a faulty responder
      send(8'hFF);
      tick();
      tick();
      pop_chk("t2_wrap", 8'h00, 2'd0);
      chk("t2_err0", err_cnt, 16'h0);
      mode = 1;
      send(8'h20);
      tick();
      tick();
      pop_chk("t2_mis", 8'h10, 2'd1);
      chk("t2_err1", err_cnt, 16'h1);
      // 3: timeout after 15 WAIT cycles, then a late reply counts as spurious
      mode = 2;
      send(8'h33);
      tick();
      repeat (14) tick();
      chk("t3_not_yet", 16'(rsp_valid), 16'h0);
      tick();
      chk("t3_err2", err_cnt, 16'h2);
      chk("t3_spur0", spurious_cnt, 16'h0);
      pop_chk("t3_to", 8'h00, 2'd2);
      inj = 1'b1;
      tick();
      inj = 1'b0;
      chk("t3_spur1", spurious_cnt, 16'h1);
      // 4: full FIFO blocks acceptance until a pop
      mode = 0;
      send(8'h10);
      send(8'h11);
      send(8'h12);
      send(8'h13);
      tick();
      tick();
      req_valid = 1'b1;
      req_data  = 8'h14;
      chk("t4_full_block", 16'(req_ready), 16'h0);
      tick();
      tick();
      chk("t4_still_block", 16'(req_ready), 16'h0);
      chk("t4_head", 16'(rsp_data), 16'h0011);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t4_unblock", 16'(req_ready), 16'h1);
      send(8'h14);
      tick();
      tick();
      pop_chk("t4_r12", 8'h12, 2'd0);
      pop_chk("t4_r13", 8'h13, 2'd0);
      pop_chk("t4_r14", 8'h14, 2'd0);
      pop_chk("t4_r15", 8'h15, 2'd0);
      chk("t4_empty", 16'(rsp_valid), 16'h0);
      // 5: stream of eight requests with a randomly stalling consumer
      fork
         begin
            for (int i = 0; i < 8; i++) send(8'(i));
         end
         begin
            int got = 0;
            for (int c = 0; c < 400 && got < 8; c++) begin
               rsp_ready = 1'($urandom_range(0, 1));
               if (rsp_valid && rsp_ready) begin
                  chk("t5_data", 16'(rsp_data), 16'(got + 1));
                  chk("t5_status", 16'(rsp_status), 16'h0);
                  got++;
               end
               tick();
            end
            rsp_ready = 1'b0;
            chk("t5_count", 16'(got), 16'h8);
         end
      join
      chk("t5_err", err_cnt, 16'h2);
      chk("t5_spur", spurious_cnt, 16'h1);
      // 6: asynchronous reset mid-transaction with a buffered response
      send(8'h40);
      tick();
      tick();
      mode = 2;
      send(8'h77);
      tick();
      chk("t6_pre_valid", 16'(rsp_valid), 16'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_bus_ready", 16'(bus_ready), 16'h0);
      chk("t6_rst_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("t6_rst_bus_data", 16'(bus_data_in), 16'h0);
      chk("t6_rst_err", err_cnt, 16'h0);
      chk("t6_rst_spur", spurious_cnt, 16'h0);
      tick();
      chk("t6_hold_valid", 16'(rsp_valid), 16'h0);
      mode = 0;
      #2;
      rst_n = 1'b1;
      tick();
      send(8'h5A);
      tick();
      tick();
      pop_chk("t6_rsp", 8'h5B, 2'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
